// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver for the STI serial link.
// Collects an 8/16/24/32-bit frame under a latched configuration, recovers
// the 16-bit data word and the left-aligned frame, and reports padding
// errors and aborted (gapped) frames.
// Optional byte-write output stream: define STI_RX_BYTE_OUT_EN.
module sti_rx #(
  parameter int GAP_TOL = 0,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        so_data,
  input  logic        so_valid,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_low,
  input  logic        cfg_fill,
  output logic        po_valid,
  output logic [15:0] po_data,
  output logic [31:0] po_frame,
  output logic        po_pad_err,
  output logic        po_err
`ifdef STI_RX_BYTE_OUT_EN
  ,
  output logic [7:0]        po_byte,
  output logic              po_byte_wr,
  output logic [ADDR_W-1:0] po_addr,
  output logic              po_wrap
`endif
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_next;
  logic [1:0]  len_q;
  logic        msb_q, low_q, fill_q;
  logic [31:0] w_q, w_next;
  logic [5:0]  count_q, count_next;
  logic [3:0]  gap_q, gap_next;
  logic        done, abort;

  logic        take_cfg;
  logic [1:0]  len_eff;
  logic        msb_eff, low_eff, fill_eff;
  logic [5:0]  last_idx, rev_idx;
  logic [4:0]  pos;

  logic [31:0] frame_next;
  logic [15:0] data_next;
  logic        pad_next;

  // A config load in IDLE applies immediately to a frame starting this cycle
  always_comb begin
    take_cfg = (state == IDLE) && cfg_load;
    len_eff  = take_cfg ? cfg_length : len_q;
    msb_eff  = take_cfg ? cfg_msb    : msb_q;
    low_eff  = take_cfg ? cfg_low    : low_q;
    fill_eff = take_cfg ? cfg_fill   : fill_q;
    last_idx = {1'b0, len_eff, 3'b111};
    rev_idx  = last_idx - count_q;
  end

  // Next-state logic: bit capture, completion detection and gap abort
  always_comb begin
    state_next = state;
    w_next     = w_q;
    count_next = count_q;
    gap_next   = gap_q;
    done       = 1'b0;
    abort      = 1'b0;
    pos        = '0;
    case (state)
      IDLE: begin
        if (so_valid) begin
          pos         = msb_eff ? last_idx[4:0] : 5'd0;
          w_next      = '0;
          w_next[pos] = so_data;
          count_next  = 6'd1;
          gap_next    = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (so_valid) begin
          pos         = msb_eff ? rev_idx[4:0] : count_q[4:0];
          w_next[pos] = so_data;
          count_next  = count_q + 6'd1;
          gap_next    = '0;
          if (count_q == last_idx) begin
            done       = 1'b1;
            count_next = '0;
            state_next = IDLE;
          end
        end else if (gap_q >= 4'(GAP_TOL)) begin
          abort      = 1'b1;
          count_next = '0;
          gap_next   = '0;
          state_next = IDLE;
        end else begin
          gap_next = gap_q + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Recover the data word, left-aligned frame and pad flag from the word
  // as it will stand once the current bit is captured
  always_comb begin
    frame_next = w_next;
    data_next  = w_next[15:0];
    pad_next   = 1'b0;
    case (len_eff)
      2'b00: begin
        frame_next = {w_next[7:0], 24'h0};
        data_next  = low_eff ? {w_next[7:0], 8'h00} : {8'h00, w_next[7:0]};
      end
      2'b01: begin
        frame_next = {w_next[15:0], 16'h0};
        data_next  = w_next[15:0];
      end
      2'b10: begin
        frame_next = {w_next[23:0], 8'h0};
        data_next  = fill_eff ? w_next[23:8] : w_next[15:0];
        pad_next   = fill_eff ? |w_next[7:0] : |w_next[23:16];
      end
      default: begin
        frame_next = w_next;
        data_next  = fill_eff ? w_next[31:16] : w_next[15:0];
        pad_next   = fill_eff ? |w_next[15:0] : |w_next[31:16];
      end
    endcase
  end

  // State, shift register, counters and latched configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      w_q     <= '0;
      count_q <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      msb_q   <= 1'b0;
      low_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state   <= state_next;
      w_q     <= w_next;
      count_q <= count_next;
      gap_q   <= gap_next;
      if (take_cfg) begin
        len_q  <= cfg_length;
        msb_q  <= cfg_msb;
        low_q  <= cfg_low;
        fill_q <= cfg_fill;
      end
    end
  end

  // Registered outputs: pulses each cycle, data held until next completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      po_valid   <= 1'b0;
      po_err     <= 1'b0;
      po_data    <= '0;
      po_frame   <= '0;
      po_pad_err <= 1'b0;
    end else begin
      po_valid <= done;
      po_err   <= abort;
      if (done) begin
        po_data    <= data_next;
        po_frame   <= frame_next;
        po_pad_err <= pad_next;
      end
    end
  end

`ifdef STI_RX_BYTE_OUT_EN
  logic [31:0]       emit_buf;
  logic [2:0]        emit_left;
  logic [ADDR_W-1:0] addr_up;

  // Address of the next write: advances once per completed write
  always_comb begin
    addr_up = po_byte_wr ? po_addr + ADDR_W'(1) : po_addr;
  end

  // Copy each completed frame and stream its bytes out MSB byte first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emit_buf   <= '0;
      emit_left  <= '0;
      po_byte    <= '0;
      po_byte_wr <= 1'b0;
      po_addr    <= '0;
      po_wrap    <= 1'b0;
    end else begin
      po_byte_wr <= 1'b0;
      po_wrap    <= 1'b0;
      po_addr    <= addr_up;
      if (done) begin
        emit_buf  <= frame_next;
        emit_left <= {1'b0, len_eff} + 3'd1;
      end else if (emit_left != 3'd0) begin
        po_byte    <= emit_buf[31:24];
        po_byte_wr <= 1'b1;
        po_wrap    <= &addr_up;
        emit_buf   <= {emit_buf[23:0], 8'h00};
        emit_left  <= emit_left - 3'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: randomized scoreboard bench for sti_rx.
// Stimulus pushes expected frames (computed from the frame rules) into a
// queue; an independent monitor pops and compares on every output pulse.
module tb_sti_rx;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              so_data, so_valid, cfg_load;
  logic [1:0]        cfg_length;
  logic              cfg_msb, cfg_low, cfg_fill;
  logic              po_valid, po_pad_err, po_err;
  logic [15:0]       po_data;
  logic [31:0]       po_frame;
`ifdef STI_RX_BYTE_OUT_EN
  logic [7:0]        po_byte;
  logic              po_byte_wr, po_wrap;
  logic [ADDR_W-1:0] po_addr;
`endif

  always #5 clk = ~clk;

  sti_rx #(.GAP_TOL(0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
    .cfg_load(cfg_load), .cfg_length(cfg_length), .cfg_msb(cfg_msb),
    .cfg_low(cfg_low), .cfg_fill(cfg_fill),
    .po_valid(po_valid), .po_data(po_data), .po_frame(po_frame),
    .po_pad_err(po_pad_err), .po_err(po_err)
`ifdef STI_RX_BYTE_OUT_EN
    , .po_byte(po_byte), .po_byte_wr(po_byte_wr), .po_addr(po_addr), .po_wrap(po_wrap)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] frame;
    logic        pad;
  } exp_t;

  typedef struct packed {
    logic [7:0]        value;
    logic [ADDR_W-1:0] addr;
    logic              wrap;
  } byte_t;

  exp_t  exp_q[$];
  byte_t byte_q[$];
  int    err_pending = 0;
  int    n_checks = 0;
  int    n_fail = 0;
  logic [ADDR_W-1:0] tb_addr = '0;

  // Configuration the bench believes the receiver currently holds
  logic [1:0] cur_len = 2'b00;
  logic       cur_msb = 1'b0, cur_low = 1'b0, cur_fill = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: expected outputs from the received word W and the frame rules
  task automatic pushExpected(input logic [1:0] len, input logic low, input logic fill,
                              input logic [31:0] w);
    exp_t e;
    int   n, pw;
    n  = 8 * (int'(len) + 1);
    pw = n - 16;
    e.frame = w << (32 - n);
    if (n == 8) begin
      e.data = low ? 16'(w * 256) : 16'(w);
      e.pad  = 1'b0;
    end else if (n == 16) begin
      e.data = 16'(w);
      e.pad  = 1'b0;
    end else if (fill) begin
      e.data = 16'(w >> pw);
      e.pad  = (w % (32'd1 << pw)) != 0;
    end else begin
      e.data = 16'(w);
      e.pad  = (w >> 16) != 0;
    end
    exp_q.push_back(e);
    for (int i = 0; i < n / 8; i++) begin
      byte_t b;
      b.value = 8'(e.frame >> (24 - 8 * i));
      b.addr  = tb_addr;
      b.wrap  = (tb_addr == {ADDR_W{1'b1}});
      byte_q.push_back(b);
      tb_addr = tb_addr + 1'b1;
    end
  endtask

  // Drive one frame carrying word w; abort_at >= 1 inserts a gap before that bit
  task automatic applyStimulus(input logic [1:0] len, input logic msb, input logic low,
                               input logic fill, input logic [31:0] w, input bit load,
                               input bit junk, input int abort_at);
    int n;
    if (load) begin
      cur_len = len; cur_msb = msb; cur_low = low; cur_fill = fill;
    end
    n = 8 * (int'(cur_len) + 1);
    if (n < 32) w = w & ((32'd1 << n) - 1);
    if (abort_at < 0) pushExpected(cur_len, cur_low, cur_fill, w);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        so_valid = 1'b0;
        cfg_load = 1'b0;
        err_pending++;
        @(posedge clk); #1;
        return;
      end
      so_valid = 1'b1;
      so_data  = cur_msb ? w[n-1-k] : w[k];
      if (k == 0) begin
        cfg_load = load; cfg_length = len; cfg_msb = msb; cfg_low = low; cfg_fill = fill;
      end else if (junk) begin
        cfg_load = 1'($urandom); cfg_length = 2'($urandom);
        cfg_msb = 1'($urandom); cfg_low = 1'($urandom); cfg_fill = 1'($urandom);
      end else begin
        cfg_load = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idleCycles(input int n);
    so_valid = 1'b0;
    cfg_load = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, po_valid, 0);
    checkOutput({tag, "_err"}, po_err, 0);
    checkOutput({tag, "_data"}, po_data, 0);
    checkOutput({tag, "_frame"}, po_frame, 0);
    checkOutput({tag, "_pad"}, po_pad_err, 0);
  endtask

  // Monitor: compare every output pulse against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (po_valid || po_err) checkOutput("valid_err_exclusive", po_valid & po_err, 0);
      if (po_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_valid", po_valid, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("po_data", po_data, e.data);
          checkOutput("po_frame", po_frame, e.frame);
          checkOutput("po_pad_err", po_pad_err, e.pad);
        end
      end
      if (po_err) begin
        if (err_pending == 0) checkOutput("unexpected_err", po_err, 0);
        else begin
          err_pending--;
          checkOutput("err_pulse", po_err, 1);
        end
      end
    end
  end

`ifdef STI_RX_BYTE_OUT_EN
  // Monitor for the byte-write stream
  always @(negedge clk) begin
    byte_t b;
    if (!reset && po_byte_wr) begin
      if (byte_q.size() == 0) checkOutput("unexpected_byte_wr", po_byte_wr, 0);
      else begin
        b = byte_q.pop_front();
        checkOutput("po_byte", po_byte, b.value);
        checkOutput("po_addr", po_addr, b.addr);
        checkOutput("po_wrap", po_wrap, b.wrap);
      end
    end
  end
`endif

  initial begin
    logic [1:0]  len;
    logic [31:0] w;
    int          n, ab;
    reset = 1'b1; so_data = 1'b0; so_valid = 1'b0; cfg_load = 1'b0;
    cfg_length = 2'b00; cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;
    idleCycles(2);

    // Directed frames
    applyStimulus(2'b01, 1, 0, 0, 32'h0000A5C3, 1, 0, -1); idleCycles(2);
    applyStimulus(2'b00, 0, 0, 0, 32'h0000003C, 1, 0, -1); idleCycles(1);
    applyStimulus(2'b00, 0, 1, 0, 32'h0000003C, 1, 1, -1); idleCycles(2);
    applyStimulus(2'b11, 1, 0, 0, 32'h00001234, 1, 0, -1);
    applyStimulus(2'b11, 1, 0, 0, 32'h80001234, 1, 0, -1); idleCycles(2);
    applyStimulus(2'b01, 1, 0, 0, 32'h0000FFFF, 1, 0, 5);
    applyStimulus(2'b01, 1, 0, 0, 32'h0000FFFF, 0, 0, -1); idleCycles(3);

    // Reset in the middle of a 24-bit frame: nothing may come out
    cfg_load = 1'b1; cfg_length = 2'b10; cfg_msb = 1'b1; cfg_fill = 1'b1;
    for (int k = 0; k < 10; k++) begin
      so_valid = 1'b1; so_data = 1'($urandom);
      @(posedge clk); #1;
      cfg_load = 1'b0;
    end
    so_valid = 1'b0;
    reset = 1'b1;
    #2;
    checkAllZero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    cur_len = 2'b00; cur_msb = 1'b0; cur_low = 1'b0; cur_fill = 1'b0;
    tb_addr = '0;
    idleCycles(3);
    applyStimulus(2'b10, 1, 0, 1, 32'h00BEEF00, 1, 0, -1); idleCycles(2);

    // Randomized frames: back-to-back, reused config, junk loads, aborts
    for (int i = 0; i < 60; i++) begin
      len = 2'($urandom);
      w   = $urandom;
      if ($urandom_range(0, 1) == 0) w = ($urandom_range(0, 1) == 0) ? (w & 32'h0000FFFF) : (w & 32'hFFFF0000);
      n  = 8 * (int'(($urandom_range(0, 3) == 0) ? cur_len : len) + 1);
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 7) : -1;
      applyStimulus(len, 1'($urandom), 1'($urandom), 1'($urandom), w,
                    $urandom_range(0, 3) != 0, 1'($urandom), (ab < n) ? ab : -1);
      idleCycles($urandom_range(0, 2));
    end

    idleCycles(10);
    checkOutput("frames_outstanding", exp_q.size(), 0);
    checkOutput("errs_outstanding", err_pending, 0);
`ifdef STI_RX_BYTE_OUT_EN
    checkOutput("bytes_outstanding", byte_q.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
